// File: rtl/nibble_serializer.sv
// rtl/nibble_serializer.sv - 4-bit parallel-to-serial framer with registered outputs
// Optional even-parity trailer bit: define NIBBLE_SERIALIZER_PARITY_EN.

module nibble_serializer #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] Din,
    input  logic       Ld,
    output logic       Rdy,
    output logic       Sout,
    output logic       Sval,
    output logic       Frm,
    output logic       Last
);

`ifdef NIBBLE_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

    state_t     state_q, state_d;
    logic [3:0] shreg_q, shreg_d;
    logic [1:0] cnt_q, cnt_d;
    logic       rdy_q, rdy_d;
    logic       sout_q, sout_d;
    logic       sval_q, sval_d;
    logic       frm_q, frm_d;
    logic       last_q, last_d;
`ifdef NIBBLE_SERIALIZER_PARITY_EN
    logic       par_q, par_d;
`endif

    function automatic logic head_bit(input logic [3:0] s);
        return MSB_FIRST ? s[3] : s[0];
    endfunction

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef NIBBLE_SERIALIZER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (Ld) begin
                    shreg_d = Din;
                    cnt_d   = 2'd0;
                    state_d = SHIFT;
`ifdef NIBBLE_SERIALIZER_PARITY_EN
                    par_d   = ^Din;
`endif
                end
            end
            SHIFT: begin
                cnt_d   = cnt_q + 2'd1;
                shreg_d = MSB_FIRST ? {shreg_q[2:0], 1'b0} : {1'b0, shreg_q[3:1]};
                if (cnt_q == 2'd3) begin
`ifdef NIBBLE_SERIALIZER_PARITY_EN
                    state_d = PAR;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef NIBBLE_SERIALIZER_PARITY_EN
            PAR: begin
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next-state values so that they come straight from flops
    always_comb begin
        rdy_d  = 1'b1;
        sval_d = 1'b0;
        sout_d = 1'b0;
        frm_d  = 1'b0;
        last_d = 1'b0;
        case (state_d)
            SHIFT: begin
                rdy_d  = 1'b0;
                sval_d = 1'b1;
                sout_d = head_bit(shreg_d);
                frm_d  = (cnt_d == 2'd0);
`ifdef NIBBLE_SERIALIZER_PARITY_EN
                last_d = 1'b0;
`else
                last_d = (cnt_d == 2'd3);
`endif
            end
`ifdef NIBBLE_SERIALIZER_PARITY_EN
            PAR: begin
                rdy_d  = 1'b0;
                sval_d = 1'b1;
                sout_d = par_d;
                last_d = 1'b1;
            end
`endif
            default: begin
                rdy_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            shreg_q <= 4'd0;
            cnt_q   <= 2'd0;
            rdy_q   <= 1'b1;
            sout_q  <= 1'b0;
            sval_q  <= 1'b0;
            frm_q   <= 1'b0;
            last_q  <= 1'b0;
`ifdef NIBBLE_SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            sout_q  <= sout_d;
            sval_q  <= sval_d;
            frm_q   <= frm_d;
            last_q  <= last_d;
`ifdef NIBBLE_SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign Rdy  = rdy_q;
    assign Sout = sout_q;
    assign Sval = sval_q;
    assign Frm  = frm_q;
    assign Last = last_q;

endmodule

// File: tb/tb_nibble_serializer.sv
// tb/tb_nibble_serializer.sv - scoreboard bench for nibble_serializer, MSB-first and LSB-first instances
// Honours NIBBLE_SERIALIZER_PARITY_EN when defined for the build.

module tb_nibble_serializer;

`ifdef NIBBLE_SERIALIZER_PARITY_EN
    localparam bit PARITY = 1'b1;
`else
    localparam bit PARITY = 1'b0;
`endif
    localparam int FRAME_LEN = PARITY ? 5 : 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] Din = 4'd0;
    logic       Ld  = 1'b0;

    logic rdy_m, sout_m, sval_m, frm_m, last_m;
    logic rdy_l, sout_l, sval_l, frm_l, last_l;

    int vectors = 0;
    int miscompares = 0;
    int left = 0;
    int cyc = 0;
    logic [2:0] q_m[$];
    logic [2:0] q_l[$];
    logic [9:0] exp_v;
    wire  [9:0] obs_v = {rdy_m, sval_m, sout_m, frm_m, last_m, rdy_l, sval_l, sout_l, frm_l, last_l};

    always #5 CLK = ~CLK;

    nibble_serializer #(.MSB_FIRST(1'b1)) dut_msb (
        .CLK(CLK), .RST(RST), .Din(Din), .Ld(Ld),
        .Rdy(rdy_m), .Sout(sout_m), .Sval(sval_m), .Frm(frm_m), .Last(last_m)
    );

    nibble_serializer #(.MSB_FIRST(1'b0)) dut_lsb (
        .CLK(CLK), .RST(RST), .Din(Din), .Ld(Ld),
        .Rdy(rdy_l), .Sout(sout_l), .Sval(sval_l), .Frm(frm_l), .Last(last_l)
    );

    // Expected {Sout, Frm, Last} for every bit of a captured nibble, both bit orders
    task automatic push_frame(input logic [3:0] d);
        for (int i = 0; i < 4; i++) begin
            q_m.push_back({d[3 - i], i == 0, (i == 3) && !PARITY});
            q_l.push_back({d[i],     i == 0, (i == 3) && !PARITY});
        end
        if (PARITY) begin
            q_m.push_back({^d, 1'b0, 1'b1});
            q_l.push_back({^d, 1'b0, 1'b1});
        end
    endtask

    // Drive one cycle at the falling edge, advance the reference model, land on the next falling edge
    task automatic step(input logic ld, input logic [3:0] din, input logic rstn);
        Ld  = ld;
        Din = din;
        RST = rstn;
        if (!rstn) begin
            q_m.delete();
            q_l.delete();
            left = 0;
        end else if (left == 0 && ld) begin
            push_frame(din);
            left = FRAME_LEN;
        end else if (left > 0) begin
            left = left - 1;
        end
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
    endtask

    task automatic next_expect(output logic [9:0] e);
        logic [2:0] em, el;
        if (left != 0 && q_m.size() > 0 && q_l.size() > 0) begin
            em = q_m.pop_front();
            el = q_l.pop_front();
            e  = {2'b01, em, 2'b01, el};
        end else begin
            e  = 10'b10000_10000;
        end
    endtask

    task automatic test_reset();
        step(1'b1, 4'hF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step(1'b0, 4'h0, 1'b1);
            next_expect(exp_v);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL reset_idle cyc%0d got %b expected %b", cyc, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_single_frame();
        for (int i = 0; i < 8; i++) begin
            step(i == 0, (i == 0) ? 4'b1011 : 4'b0100, 1'b1);
            next_expect(exp_v);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL single_1011 cyc%0d got %b expected %b", cyc, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_ignored_ld();
        logic [3:0] dins [8] = '{4'h9, 4'hC, 4'h3, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0};
        logic [7:0] lds = 8'b0000_1011;
        for (int i = 0; i < 8; i++) begin
            step(lds[i], dins[i], 1'b1);
            next_expect(exp_v);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL busy_ld cyc%0d got %b expected %b", cyc, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 18; i++) begin
            step(i < 11, (i == 0) ? 4'hA : 4'h5, 1'b1);
            next_expect(exp_v);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL back_to_back cyc%0d got %b expected %b", cyc, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] rsts = 8'b1111_1011;
        logic [7:0] lds  = 8'b0000_1001;
        for (int i = 0; i < 12; i++) begin
            step((i < 8) ? lds[i] : 1'b0, (i == 0) ? 4'hF : 4'h3, (i < 8) ? rsts[i] : 1'b1);
            next_expect(exp_v);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL reset_mid cyc%0d got %b expected %b", cyc, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom_range(0, 15) != 0);
            next_expect(exp_v);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL random cyc%0d got %b expected %b", cyc, obs_v, exp_v);
            end
        end
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 4'h0, 1'b1);
            next_expect(exp_v);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL random_drain cyc%0d got %b expected %b", cyc, obs_v, exp_v);
            end
        end
        vectors++;
        if (q_m.size() != 0 || q_l.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty got %0d/%0d pending expected 0", q_m.size(), q_l.size());
        end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_single_frame();
        test_ignored_ld();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
